// File: rtl/formato_pkg.sv
// Shared types and address map for the pixel-memory arbiter and its neighbours.
package formato_pkg;

    localparam int unsigned STALL_W = 16;

    localparam logic [18:0] OUT_BASE  = 19'h40000;
    localparam logic [18:0] PERF_BASE = 19'h58000;

    typedef enum logic [1:0] {
        OWN_HOST   = 2'd0,
        START_WAIT = 2'd1,
        OWN_ENG    = 2'd2,
        DRAIN      = 2'd3
    } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port pixel memory between the host loader and the
// downscaling engine, and sequences the engine start/run/drain handshake.
module mem_arbiter
    import formato_pkg::*;
#(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [DATA_W-1:0]  host_rdata,
    input  logic               host_start,
    output logic               eng_start,
    input  logic               eng_busy,
    input  logic               eng_we,
    input  logic [ADDR_W-1:0]  eng_addr,
    input  logic [DATA_W-1:0]  eng_wdata,
    output logic [DATA_W-1:0]  eng_rdata,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [1:0]         owner,
    output logic               run_done,
    output logic               timeout_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned TO_W = $clog2(START_TIMEOUT + 1);

    owner_t            r_state;
    owner_t            w_state_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_eng_start;
    logic              r_timeout_err;
    logic              r_rvalid;
    logic              r_run_done;
    logic              w_start_ok;
    logic              w_timeout;
    logic              w_host_gnt;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // A start is refused while read data is still coming back to the host.
    assign w_start_ok = (r_state == OWN_HOST) && host_start && !r_rvalid;
    assign w_timeout  = (r_state == START_WAIT) && !eng_busy
                        && (r_to_cnt == TO_W'(START_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OWN_HOST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OWN_HOST:   if (w_start_ok) w_state_nxt = START_WAIT;
            START_WAIT: begin
                if (eng_busy) begin
                    w_state_nxt = OWN_ENG;
                end else if (w_timeout) begin
                    w_state_nxt = OWN_HOST;
                end
            end
            OWN_ENG:    if (!eng_busy) w_state_nxt = DRAIN;
            DRAIN:      w_state_nxt = OWN_HOST;
            default:    w_state_nxt = OWN_HOST;
        endcase
    end

    // Memory mux; the engine keeps address/data from START_WAIT on so its reads see no gap.
    always_comb begin
        w_host_gnt  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = eng_addr;
        w_mem_wdata = eng_wdata;
        case (r_state)
            OWN_HOST: begin
                w_host_gnt  = host_req && !host_start && !rst;
                w_mem_we    = host_we && w_host_gnt;
                w_mem_addr  = host_addr;
                w_mem_wdata = host_wdata;
            end
            START_WAIT: w_mem_we = 1'b0;
            OWN_ENG:    w_mem_we = eng_we;
            DRAIN:      w_mem_we = eng_we;
            default:    w_mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_start   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rvalid      <= 1'b0;
            r_run_done    <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_rvalid   <= w_host_gnt && !host_we;
            r_run_done <= (r_state == DRAIN);
            r_to_cnt   <= (r_state == START_WAIT) ? r_to_cnt + TO_W'(1) : '0;
            if (w_start_ok) begin
                r_eng_start   <= 1'b1;
                r_timeout_err <= 1'b0;
            end else if ((r_state == START_WAIT) && (eng_busy || w_timeout)) begin
                r_eng_start <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (host_req && !w_host_gnt),
        .o_cnt (stall_cnt)
    );

    assign host_gnt    = w_host_gnt;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = mem_rdata;
    assign eng_start   = r_eng_start;
    assign eng_rdata   = mem_rdata;
    assign mem_we      = w_mem_we;
    assign mem_addr    = w_mem_addr;
    assign mem_wdata   = w_mem_wdata;
    assign owner       = 2'(r_state);
    assign run_done    = r_run_done;
    assign timeout_err = r_timeout_err;

endmodule
